cheb_poly_eval_n: RTL

//  Sequential Chebyshev series evaluator, order ORDER, one shared multiplier and one shared adder.

---
 rtl/cheb_poly_eval_n.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/cheb_poly_eval_n.sv
// -----------------------------------------------------------------------------
// cheb_poly_eval_n
//   Sequential Chebyshev series evaluator with one shared multiplier and one
//   shared adder. Computes
//       sum = SUM_{k=0..ORDER} coeffs[k] * T_{ORDER-k}(x)
//   with T0 = 1, T1 = x, Tk = 2x*T(k-1) - T(k-2). It is used by the LPC-to-LSP
//   root search and is called once per grid point.
//
//   All words are sign-magnitude (bit N-1 = sign), Q fractional bits.
//
//   Optional feature macro: CHEB_SAT_EN
//     defined   : multiply/add overflow clamps the magnitude to all ones (sign
//                 kept) and sets o_ovf, which stays set until the next INIT.
//     undefined : overflow wraps (upper bits dropped), o_ovf is tied to 0.
//
// Ports
//   clk       in   1              clock, rising edge
//   rst       in   1              asynchronous active-low reset
//   i_start   in   1              request, sampled only in IDLE
//   i_x       in   N              evaluation point
//   i_coeffs  in   (ORDER+1)*N    coeffs[k] = bits [k*N +: N]; coeffs[0] pairs with T_ORDER
//   o_sum     out  N              result, held from done until the next evaluation starts
//   o_busy    out  1              high from the edge after acceptance until done
//   o_done    out  1              one-cycle pulse, o_sum valid in that cycle
//   o_ovf     out  1              saturation occurred during this evaluation
// -----------------------------------------------------------------------------
module cheb_poly_eval_n #(
    parameter int N     = 32,
    parameter int Q     = 24,
    parameter int ORDER = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [N-1:0]             i_x,
    input  logic [(ORDER+1)*N-1:0]   i_coeffs,
    output logic [N-1:0]             o_sum,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_ovf
);

    localparam int M  = N - 1;                 // magnitude width
    localparam int IW = $clog2(ORDER + 1);     // T / coefficient index width

    localparam logic [IW-1:0] LAST = IW'(ORDER);
    localparam logic [N-1:0]  ONE  = {{(N-1-Q){1'b0}}, 1'b1, {Q{1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_REC_MUL = 3'd2;
    localparam logic [2:0] S_REC_ADD = 3'd3;
    localparam logic [2:0] S_ACC_MUL = 3'd4;
    localparam logic [2:0] S_ACC_ADD = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Returns {overflow, sign, magnitude}; magnitude is the wrapped value.
    function automatic logic [N:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*M-1:0] full;
        logic [2*M-1:0] shifted;
        full    = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
        shifted = full >> Q;
        return {(|shifted[2*M-1:M]), a[N-1] ^ b[N-1], shifted[M-1:0]};
    endfunction

    // Sign-magnitude add; returns {overflow, sign, magnitude}.
    function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [M:0] s;
        logic       sg;
        if (a[N-1] == b[N-1]) begin
            s  = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
            sg = a[N-1];
        end else if (a[M-1:0] >= b[M-1:0]) begin
            s  = {1'b0, a[M-1:0] - b[M-1:0]};
            sg = a[N-1];
        end else begin
            s  = {1'b0, b[M-1:0] - a[M-1:0]};
            sg = b[N-1];
        end
        return {s[M], sg, s[M-1:0]};
    endfunction

    // Zero results are always reported as +0.
    function automatic logic [N-1:0] sm_norm(input logic [N-1:0] v);
        return (v[M-1:0] == '0) ? '0 : v;
    endfunction

`ifdef CHEB_SAT_EN
    function automatic logic [N-1:0] sm_sat(input logic ov, input logic [N-1:0] v);
        return ov ? {v[N-1], {M{1'b1}}} : v;
    endfunction
`endif

    logic [2:0]    r_state;
    logic [IW-1:0] r_k;
    logic [IW-1:0] r_j;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_x2;
    logic [N-1:0]  r_prod;
    logic [N-1:0]  r_sum;
    logic [N-1:0]  r_t [0:ORDER];
    logic [N-1:0]  r_c [0:ORDER];

    logic [IW-1:0] w_km1;
    logic [IW-1:0] w_km2;
    logic [IW-1:0] w_cidx;
    logic [N-1:0]  w_ma;
    logic [N-1:0]  w_mb;
    logic [N-1:0]  w_aa;
    logic [N-1:0]  w_ab;
    logic [N:0]    w_mul_raw;
    logic [N:0]    w_add_raw;
    logic          w_mul_ovf;
    logic          w_add_ovf;
    logic [N-1:0]  w_mul_res;
    logic [N-1:0]  w_add_res;
    logic          w_acc_phase;

    assign w_km1       = r_k - IW'(1);
    assign w_km2       = r_k - IW'(2);
    assign w_cidx      = LAST - r_j;
    assign w_acc_phase = (r_state == S_ACC_MUL) || (r_state == S_ACC_ADD);

    // Shared operand muxes: recurrence phase vs accumulation phase.
    always_comb begin
        w_ma = r_x2;
        w_mb = r_t[w_km1];
        w_aa = r_prod;
        w_ab = {~r_t[w_km2][N-1], r_t[w_km2][M-1:0]};   // -T(k-2): flip the sign bit
        if (w_acc_phase) begin
            w_ma = r_c[w_cidx];
            w_mb = r_t[r_j];
            w_aa = r_sum;
            w_ab = r_prod;
        end
    end

    assign w_mul_raw = sm_mul(w_ma, w_mb);
    assign w_add_raw = sm_add(w_aa, w_ab);
    assign w_mul_ovf = w_mul_raw[N];
    assign w_add_ovf = w_add_raw[N];

`ifdef CHEB_SAT_EN
    logic r_ovf;
    assign w_mul_res = sm_norm(sm_sat(w_mul_ovf, w_mul_raw[N-1:0]));
    assign w_add_res = sm_norm(sm_sat(w_add_ovf, w_add_raw[N-1:0]));
    assign o_ovf     = r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_INIT:               r_ovf <= 1'b0;
                S_REC_MUL, S_ACC_MUL: r_ovf <= r_ovf | w_mul_ovf;
                S_REC_ADD, S_ACC_ADD: r_ovf <= r_ovf | w_add_ovf;
                default:              r_ovf <= r_ovf;
            endcase
        end
    end
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_mul_ovf | w_add_ovf;
    assign w_mul_res    = sm_norm(w_mul_raw[N-1:0]);
    assign w_add_res    = sm_norm(w_add_raw[N-1:0]);
    assign o_ovf        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_j     <= '0;
            r_x     <= '0;
            r_x2    <= '0;
            r_prod  <= '0;
            r_sum   <= '0;
            for (int i = 0; i <= ORDER; i++) begin
                r_t[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x <= i_x;
                        for (int i = 0; i <= ORDER; i++) begin
                            r_c[i] <= i_coeffs[i*N +: N];
                        end
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    // 2x: shift the magnitude, keep the sign; top magnitude bit wraps out
                    r_x2    <= sm_norm({r_x[N-1], r_x[M-2:0], 1'b0});
                    r_t[0]  <= ONE;
                    r_t[1]  <= r_x;
                    r_sum   <= '0;
                    r_k     <= IW'(2);
                    r_j     <= '0;
                    r_state <= S_REC_MUL;
                end
                S_REC_MUL: begin
                    r_prod  <= w_mul_res;
                    r_state <= S_REC_ADD;
                end
                S_REC_ADD: begin
                    r_t[r_k] <= w_add_res;
                    r_k      <= r_k + IW'(1);
                    r_j      <= '0;
                    r_state  <= (r_k == LAST) ? S_ACC_MUL : S_REC_MUL;
                end
                S_ACC_MUL: begin
                    r_prod  <= w_mul_res;
                    r_state <= S_ACC_ADD;
                end
                S_ACC_ADD: begin
                    r_sum   <= w_add_res;
                    r_j     <= r_j + IW'(1);
                    r_state <= (r_j == LAST) ? S_DONE : S_ACC_MUL;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sum  = r_sum;
    assign o_done = (r_state == S_DONE);
    assign o_busy = (r_state == S_REC_MUL) || (r_state == S_REC_ADD) ||
                    (r_state == S_ACC_MUL) || (r_state == S_ACC_ADD);

endmodule
